l1d_cache: RTL

Two-way set-associative, write-back, write-allocate L1 data cache sitting directly on the pipeline's data port (MEM stage, port b) and in front of the shared L2/arbiter. It answers word-sized loads and stores from flip-flop arrays, so hits complete in the same cycle with no stall. It fetches and evicts full 256-bit lines on misses, and exports a hit strobe for the performance counter.

---
 rtl/l1d_cache.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/l1d_cache.sv
// l1d_cache: two-way set-associative, write-back, write-allocate L1 data cache.
// Hits complete combinationally in IDLE. Misses write back a dirty victim, then
// fill the line from L2, and finally retire as a hit on the following cycle.
//
// Handshakes: mem_read/mem_write are held by the pipeline until the single-cycle
// mem_resp; pmem_read/pmem_write are held by the cache until the single-cycle
// pmem_resp, and only one of them is ever high at a time.
module l1d_cache #(
    parameter int SET_BITS = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [3:0]   mem_byte_enable,
    input  logic [31:0]  mem_address,
    input  logic [31:0]  mem_wdata,
    output logic [31:0]  mem_rdata,
    output logic         mem_resp,
    output logic         l1d_hit,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp
);
    localparam int SETS  = 1 << SET_BITS;
    localparam int TAG_W = 27 - SET_BITS;

    typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;

    state_t               state_q, state_d;
    logic [SETS-1:0]      valid_q [2];
    logic [SETS-1:0]      valid_d [2];
    logic [SETS-1:0]      dirty_q [2];
    logic [SETS-1:0]      dirty_d [2];
    logic [SETS-1:0]      lru_q, lru_d;
    logic                 missed_q, missed_d;
    logic                 victim_q, victim_d;
    logic [TAG_W-1:0]     tag_q  [2][SETS];
    logic [255:0]         data_q [2][SETS];

    logic [SET_BITS-1:0]  set_idx;
    logic [TAG_W-1:0]     req_tag;
    logic [2:0]           word_idx;
    logic                 req, hit0, hit1, hit, hit_way, victim_sel;
    logic [255:0]         hit_line, store_line, data_line;
    logic                 data_we, data_way, tag_we;

    assign set_idx  = mem_address[4+SET_BITS:5];
    assign req_tag  = mem_address[31:5+SET_BITS];
    assign word_idx = mem_address[4:2];
    assign req      = mem_read | mem_write;
    assign hit0     = valid_q[0][set_idx] && (tag_q[0][set_idx] == req_tag);
    assign hit1     = valid_q[1][set_idx] && (tag_q[1][set_idx] == req_tag);
    assign hit      = hit0 | hit1;
    assign hit_way  = ~hit0;
    assign hit_line = data_q[hit_way][set_idx];

    // Replacement choice: first invalid way, otherwise the way the LRU bit names.
    assign victim_sel = !valid_q[0][set_idx] ? 1'b0 :
                        !valid_q[1][set_idx] ? 1'b1 : lru_q[set_idx];

    // Pipeline-side outputs; a hit only counts while the FSM is idle.
    assign mem_resp  = (state_q == IDLE) && req && hit;
    assign l1d_hit   = mem_resp & ~missed_q;
    assign mem_rdata = hit_line[{word_idx, 5'b0} +: 32];

    // L2-side outputs follow the state register directly, so reset drops them at once.
    assign pmem_write   = (state_q == WRITEBACK);
    assign pmem_read    = (state_q == FILL);
    assign pmem_address = (state_q == WRITEBACK) ?
                          {tag_q[victim_q][set_idx], set_idx, 5'b0} :
                          {req_tag, set_idx, 5'b0};
    assign pmem_wdata   = data_q[victim_q][set_idx];

    // Merge the enabled store bytes into the hit line.
    always_comb begin
        store_line = hit_line;
        for (int b = 0; b < 4; b++) begin
            if (mem_byte_enable[b]) begin
                store_line[{word_idx, 5'b0} + 8'(b * 8) +: 8] = mem_wdata[b*8 +: 8];
            end
        end
    end

    // Next-state, metadata and array-write control.
    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        dirty_d   = dirty_q;
        lru_d     = lru_q;
        missed_d  = missed_q;
        victim_d  = victim_q;
        data_we   = 1'b0;
        data_way  = hit_way;
        data_line = store_line;
        tag_we    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req && hit) begin
                    lru_d[set_idx] = ~hit_way;
                    missed_d       = 1'b0;
                    if (mem_write && (mem_byte_enable != 4'b0000)) begin
                        dirty_d[hit_way][set_idx] = 1'b1;
                        data_we                   = 1'b1;
                    end
                end else if (req) begin
                    victim_d = victim_sel;
                    missed_d = 1'b1;
                    if (valid_q[victim_sel][set_idx] && dirty_q[victim_sel][set_idx]) begin
                        state_d = WRITEBACK;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            WRITEBACK: begin
                if (pmem_resp) begin
                    dirty_d[victim_q][set_idx] = 1'b0;
                    state_d                    = FILL;
                end
            end
            FILL: begin
                if (pmem_resp) begin
                    valid_d[victim_q][set_idx] = 1'b1;
                    dirty_d[victim_q][set_idx] = 1'b0;
                    data_we                    = 1'b1;
                    data_way                   = victim_q;
                    data_line                  = pmem_rdata;
                    tag_we                     = 1'b1;
                    state_d                    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and metadata registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            valid_q[0] <= '0;
            valid_q[1] <= '0;
            dirty_q[0] <= '0;
            dirty_q[1] <= '0;
            lru_q      <= '0;
            missed_q   <= 1'b0;
            victim_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            dirty_q  <= dirty_d;
            lru_q    <= lru_d;
            missed_q <= missed_d;
            victim_q <= victim_d;
        end
    end

    // Tag and data arrays; contents are qualified by valid so they need no reset.
    always_ff @(posedge clk) begin
        if (data_we) data_q[data_way][set_idx] <= data_line;
        if (tag_we)  tag_q[victim_q][set_idx]  <= req_tag;
    end
endmodule
